mem_port_arbiter: RTL and testbench

- Parametrised N-channel arbiter that lets several line-based caches (I-cache, D-cache, future L2/prefetch channels) share one slow-memory port.
- Sits between the cache `mem_*` interfaces and a single slow memory in the top level.
- Memory transactions are 128-bit lines addressed by addr[31:4].
- Adds what direct cache-to-memory wiring lacks: selectable round-robin or fixed-priority grant, a one-cycle release gap, and per-channel transaction counters.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Width of a channel index; never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection for the memory port arbiter
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int PRIO_MODE = PRIO_RR,
    parameter int IDX_W     = 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk candidates from lowest to highest precedence so the last hit is the winner
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_CH; k >= 1; k--) begin
            if (PRIO_MODE == PRIO_FIXED) begin
                cand = IDX_W'(k - 1);
            end else begin
                cand = IDX_W'((int'(ptr) + k) % N_CH);
            end
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-channel line arbiter in front of one slow memory port
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int ADDR_W    = 28,
    parameter int LINE_W    = 128,
    parameter int PRIO_MODE = PRIO_RR,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          ch_read,
    input  logic [N_CH-1:0]          ch_write,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*LINE_W-1:0]   ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [N_CH-1:0]          ch_ready,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_ready,
    output logic [N_CH*CNT_W-1:0]    txn_cnt
);

    localparam int IDX_W = idx_w(N_CH);
    localparam logic [N_CH-1:0] ONE_HOT0 = N_CH'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    arb_state_t       state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [N_CH-1:0]  req;
    logic [CNT_W-1:0] cnt [N_CH];
    logic             in_grant;
    logic             gnt_rd;
    logic             gnt_wr;
    logic             done;
    logic             aborted;

    assign req      = ch_read | ch_write;
    assign in_grant = (state == ST_GRANT);
    assign gnt_rd   = ch_read[grant];
    assign gnt_wr   = ch_write[grant];
    assign done     = in_grant && (gnt_rd || gnt_wr) && mem_ready;
    assign aborted  = in_grant && !gnt_rd && !gnt_wr;

    // Strobes are gated by the registered state so reset removes them without a clock edge
    assign mem_read  = in_grant & gnt_rd;
    assign mem_write = in_grant & gnt_wr;
    assign mem_addr  = in_grant ? ch_addr[int'(grant)*ADDR_W +: ADDR_W] : ch_addr[ADDR_W-1:0];
    assign mem_wdata = in_grant ? ch_wdata[int'(grant)*LINE_W +: LINE_W] : ch_wdata[LINE_W-1:0];
    assign ch_rdata  = mem_rdata;
    assign ch_ready  = done ? (ONE_HOT0 << grant) : '0;

    mem_arb_pick #(
        .N_CH      (N_CH),
        .PRIO_MODE (PRIO_MODE),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_cnt_out
            assign txn_cnt[gi*CNT_W +: CNT_W] = cnt[gi];
        end
    endgenerate

    // Arbitration FSM: pick in IDLE, hold the grant until completion or abort, then one GAP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= IDX_W'(N_CH - 1);
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_idx;
                        if (PRIO_MODE == PRIO_RR) begin
                            ptr <= pick_idx;
                        end
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (done) begin
                        if (cnt[grant] != CNT_MAX) begin
                            cnt[grant] <= cnt[grant] + 1'b1;
                        end
                        state <= ST_GAP;
                    end else if (aborted) begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for round-robin and fixed-priority arbiters
module tb_mem_port_arbiter;

    typedef struct {
        int           ch;
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [1:0]   ch_read;
    logic [1:0]   ch_write;
    logic [55:0]  ch_addr;
    logic [255:0] ch_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    logic [127:0] r_ch_rdata;
    logic [1:0]   r_ch_ready;
    logic         r_mem_read;
    logic         r_mem_write;
    logic [27:0]  r_mem_addr;
    logic [127:0] r_mem_wdata;
    logic [3:0]   r_txn_cnt;

    logic [127:0] f_ch_rdata;
    logic [1:0]   f_ch_ready;
    logic         f_mem_read;
    logic         f_mem_write;
    logic [27:0]  f_mem_addr;
    logic [127:0] f_mem_wdata;
    logic [31:0]  f_txn_cnt;

    int checks;
    int errors;
    exp_t sb[$];

    mem_port_arbiter #(
        .N_CH(2), .ADDR_W(28), .LINE_W(128), .PRIO_MODE(0), .CNT_W(2)
    ) dut_rr (
        .clk(clk), .rst_n(rst_n), .ch_read(ch_read), .ch_write(ch_write),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rdata(r_ch_rdata),
        .ch_ready(r_ch_ready), .mem_read(r_mem_read), .mem_write(r_mem_write),
        .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .txn_cnt(r_txn_cnt)
    );

    mem_port_arbiter #(
        .N_CH(2), .ADDR_W(28), .LINE_W(128), .PRIO_MODE(1), .CNT_W(16)
    ) dut_fx (
        .clk(clk), .rst_n(rst_n), .ch_read(ch_read), .ch_write(ch_write),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rdata(f_ch_rdata),
        .ch_ready(f_ch_ready), .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .txn_cnt(f_txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input bit wr, input logic [27:0] a, input logic [127:0] d);
        exp_t e;
        e.ch = ch; e.wr = wr; e.addr = a; e.wdata = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        ch_read = '0; ch_write = '0; mem_ready = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        sb.delete();
    endtask

    // Serve one transaction on the selected arbiter and compare it with the scoreboard head
    task automatic serve(input bit fx, input int lat, input bit rearm, output int waited);
        exp_t e;
        logic [127:0] rd;
        int n;
        n = 0;
        @(negedge clk);
        while (!(fx ? (f_mem_read | f_mem_write) : (r_mem_read | r_mem_write)) && n < 20) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        chk("strobe_seen", (n < 20), 1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("mem_addr", fx ? f_mem_addr : r_mem_addr, e.addr);
        chk("mem_read", fx ? f_mem_read : r_mem_read, !e.wr);
        chk("mem_write", fx ? f_mem_write : r_mem_write, e.wr);
        chk("proto_rw_both", fx ? (f_mem_read & f_mem_write) : (r_mem_read & r_mem_write), 0);
        if (e.wr) chk("mem_wdata", fx ? f_mem_wdata : r_mem_wdata, e.wdata);
        for (int i = 1; i < lat; i++) begin
            step();
        end
        step();
        rd = {$urandom(), $urandom(), $urandom(), $urandom()};
        mem_rdata = rd;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("ch_ready", fx ? f_ch_ready : r_ch_ready, 2'b01 << e.ch);
        chk("ch_rdata", fx ? f_ch_rdata : r_ch_rdata, rd);
        step();
        mem_ready = 1'b0;
        ch_read[e.ch] = 1'b0;
        ch_write[e.ch] = 1'b0;
        if (rearm) ch_read[e.ch] = 1'b1;
        @(negedge clk);
        chk("gap_strobe", fx ? (f_mem_read | f_mem_write) : (r_mem_read | r_mem_write), 0);
        chk("gap_ready", fx ? f_ch_ready : r_ch_ready, 0);
    endtask

    initial begin
        int w;
        int n;
        logic [127:0] wd;
        checks = 0; errors = 0;
        rst_n = 1'b0; ch_read = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        #12;
        chk("rst_mem_read", r_mem_read, 0);
        chk("rst_mem_write", r_mem_write, 0);
        chk("rst_ch_ready", r_ch_ready, 0);
        chk("rst_txn_cnt", r_txn_cnt, 0);
        chk("rst_txn_cnt_fx", f_txn_cnt, 0);
        @(negedge clk); rst_n = 1'b1;

        // Single channel-0 read, latency 5
        step();
        ch_addr[27:0] = 28'h0000123;
        push(0, 0, 28'h0000123, '0);
        ch_read[0] = 1'b1;
        @(negedge clk);
        chk("t1_not_yet", r_mem_read, 0);
        serve(0, 5, 0, w);
        chk("t1_rise_delay", w, 0);
        chk("t1_cnt", r_txn_cnt, 4'b0001);

        // Round-robin alternation with both channels requesting
        do_reset();
        ch_addr = {28'h0000020, 28'h0000010};
        push(0, 0, 28'h0000010, '0); push(1, 0, 28'h0000020, '0);
        push(0, 0, 28'h0000010, '0); push(1, 0, 28'h0000020, '0);
        step();
        ch_read = 2'b11;
        serve(0, 2, 1, w);
        serve(0, 2, 1, w);
        serve(0, 2, 0, w);
        serve(0, 2, 0, w);
        chk("rr_cnts", r_txn_cnt, {2'd2, 2'd2});

        // Fixed priority: channel 0 keeps re-requesting, channel 1 waits
        do_reset();
        push(0, 0, 28'h0000010, '0); push(0, 0, 28'h0000010, '0);
        push(0, 0, 28'h0000010, '0); push(1, 0, 28'h0000020, '0);
        step();
        ch_read = 2'b11;
        serve(1, 2, 1, w);
        serve(1, 2, 1, w);
        serve(1, 2, 0, w);
        serve(1, 2, 0, w);
        chk("fx_cnts", f_txn_cnt, {16'd1, 16'd3});

        // Channel-1 write
        do_reset();
        wd = 128'hDEADBEEF_01234567_89ABCDEF_00000001;
        step();
        ch_addr[55:28] = 28'h0ABCDEF;
        ch_wdata[255:128] = wd;
        push(1, 1, 28'h0ABCDEF, wd);
        ch_write[1] = 1'b1;
        serve(0, 3, 0, w);
        chk("wr_cnt", r_txn_cnt, {2'd1, 2'd0});

        // Asynchronous reset in the middle of a grant
        step();
        ch_addr[27:0] = 28'h0000400;
        ch_read = 2'b01;
        n = 0;
        @(negedge clk);
        while (!r_mem_read && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_strobe", r_mem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_read", r_mem_read, 0);
        chk("rst_mid_mem_read_fx", f_mem_read, 0);
        chk("rst_mid_cnt", r_txn_cnt, 0);
        chk("rst_mid_ready", r_ch_ready, 0);
        ch_read = '0;
        @(negedge clk); rst_n = 1'b1;
        sb.delete();
        ch_addr = {28'h0000020, 28'h0000010};
        push(0, 0, 28'h0000010, '0); push(1, 0, 28'h0000020, '0);
        step();
        ch_read = 2'b11;
        serve(0, 2, 0, w);
        serve(0, 2, 0, w);
        chk("post_rst_cnts", r_txn_cnt, {2'd1, 2'd1});

        // mem_ready while idle is ignored
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("idle_ready_rr", r_ch_ready, 0);
        chk("idle_ready_fx", f_ch_ready, 0);
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("idle_ready_cnt", r_txn_cnt, {2'd1, 2'd1});

        // Counter saturation at CNT_W=2 (the 16-bit instance keeps counting)
        do_reset();
        for (int i = 0; i < 5; i++) push(0, 0, 28'h0000010, '0);
        step();
        ch_read = 2'b01;
        for (int i = 0; i < 5; i++) serve(0, 1, (i < 4), w);
        chk("sat_cnt_rr", r_txn_cnt, {2'd0, 2'd3});
        chk("sat_cnt_fx", f_txn_cnt, {16'd0, 16'd5});

        // Abort during GRANT, then GAP and IDLE before the next grant
        step();
        ch_read = 2'b01;
        n = 0;
        @(negedge clk);
        while (!r_mem_read && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abort_pre_strobe", r_mem_read, 1);
        step();
        ch_read = 2'b00;
        @(negedge clk);
        chk("abort_strobe", r_mem_read, 0);
        chk("abort_ready", r_ch_ready, 0);
        step();
        ch_read = 2'b01;
        @(negedge clk);
        chk("abort_gap", r_mem_read, 0);
        chk("abort_cnt", f_txn_cnt, {16'd0, 16'd5});
        @(negedge clk);
        chk("abort_idle", r_mem_read, 0);
        @(negedge clk);
        chk("abort_regrant", r_mem_read, 1);
        push(0, 0, 28'h0000010, '0);
        serve(0, 1, 0, w);
        chk("abort_final_cnt", f_txn_cnt, {16'd0, 16'd6});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
